sender_buffer_param: RTL

Parametrised word-to-byte transmit buffer that sits between the core's output path and the UART sender. It queues DATA_W-bit words in a circular FIFO of 2**DEPTH_LOG2 entries and serialises each word into DATA_W/BYTE_W bytes, selectable MSB-first or LSB-first. A valid/ready handshake drives the sender. Full, overflow, flush and occupancy reporting are provided.

---
 rtl/sender_pkg.sv | 15 +
 rtl/sender_word_fifo.sv | 66 ++++++
 rtl/sender_buffer_param.sv | 93 +++++++++
 3 files changed

// File: rtl/sender_pkg.sv
// Shared constants and width helpers for the word-to-byte transmit buffer.
package sender_pkg;

    localparam int BYTE_W_DEFAULT = 8;

    function automatic int nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // A word must split into a whole, non-zero number of bytes.
    function automatic bit widths_ok(input int data_w, input int byte_w);
        return (byte_w > 0) && (data_w % byte_w == 0) && (data_w / byte_w >= 1);
    endfunction

endpackage

// File: rtl/sender_word_fifo.sv
// Circular word FIFO; the head word is readable in the same cycle it becomes
// the oldest entry, so the serialiser sees a new word right after the write edge.
module sender_word_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full
);
    import sender_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[tail_q] <= push_data;
    end

    assign head_data = mem[head_q];
    assign count     = count_q;
    assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));

endmodule

// File: rtl/sender_buffer_param.sv
// Transmit buffer: queues words and serialises each into bytes for the UART
// sender over a valid/ready handshake, with overflow and flush support.
module sender_buffer_param
    import sender_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = BYTE_W_DEFAULT,
    parameter int DEPTH_LOG2 = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   data,
    input  logic                start,
    input  logic                flush,
    input  logic                sender_ready,
    output logic [BYTE_W-1:0]   output_data,
    output logic                valid,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);
    localparam int NB    = nbytes(DATA_W, BYTE_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    if (!widths_ok(DATA_W, BYTE_W)) begin : g_bad_widths
        $error("sender_buffer_param: DATA_W must be a non-zero multiple of BYTE_W");
    end

    logic [DATA_W-1:0] head_data;
    logic [BYTE_W-1:0] byte_lane [NB];
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              overflow_q, overflow_d;
    logic              xfer, last_byte, pop, push, drop;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        if (MSB_FIRST) begin : g_msb
            assign byte_lane[gi] = head_data[DATA_W-1-gi*BYTE_W -: BYTE_W];
        end else begin : g_lsb
            assign byte_lane[gi] = head_data[gi*BYTE_W +: BYTE_W];
        end
    end

    // A pop frees a slot in the same edge, so a full FIFO still accepts a write then.
    assign xfer      = valid && sender_ready && !flush;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign pop       = xfer && last_byte;
    assign push      = start && !flush && (!full || pop);
    assign drop      = start && !flush && !push;

    always_comb begin
        byte_idx_d = byte_idx_q;
        overflow_d = overflow_q;
        if (flush) begin
            byte_idx_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (xfer) byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            overflow_q <= overflow_d;
        end
    end

    sender_word_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .push_data (data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full)
    );

    assign valid       = (count != '0);
    assign output_data = valid ? byte_lane[byte_idx_q] : '0;
    assign overflow    = overflow_q;

endmodule
